// File: rtl/rmii_tx_framer.sv
// Ethernet MAC transmit framer for a 50 MHz RMII link, one dibit per clock.
// Emits preamble/SFD, payload, zero padding and FCS, then holds the inter-frame gap.
module rmii_tx_framer #(
    parameter int unsigned MIN_BYTES  = 60,
    parameter int unsigned MAX_BYTES  = 1514,
    parameter int unsigned IFG_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [1:0]  txd,
    output logic        tx_en,
    output logic        crc_en,
    output logic [1:0]  crc_data,
    input  logic [31:0] fcs_in,
    output logic        frame_done,
    output logic        err_underrun,
    output logic        err_oversize
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
    } state_t;

    localparam logic [10:0] MIN_C    = 11'(MIN_BYTES);
    localparam logic [10:0] MAX_C    = 11'(MAX_BYTES);
    localparam logic [5:0]  IFG_LAST = 6'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  dib_q, dib_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [1:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        crc_en_q, crc_en_d;
    logic        done_q, done_d;
    logic        und_q, und_d;
    logic        ovr_q, ovr_d;

    // State, counters and the registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            dib_q      <= 2'd0;
            byte_q     <= 8'd0;
            last_q     <= 1'b0;
            byte_cnt_q <= 11'd0;
            sh_q       <= 32'd0;
            txd_q      <= 2'b00;
            tx_en_q    <= 1'b0;
            crc_en_q   <= 1'b0;
            done_q     <= 1'b0;
            und_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dib_q      <= dib_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            sh_q       <= sh_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            crc_en_q   <= crc_en_d;
            done_q     <= done_d;
            und_q      <= und_d;
            ovr_q      <= ovr_d;
        end
    end

    // The byte slot opens only in IDLE, DRAIN, and on the final dibit of a non-last byte.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_IDLE:  s_ready = 1'b1;
            S_DRAIN: s_ready = 1'b1;
            S_DATA:  s_ready = (dib_q == 2'd3) && !last_q;
            default: s_ready = 1'b0;
        endcase
    end

    // Next state; the line outputs are then decoded from the next-state values so they register in step.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dib_d      = dib_q;
        byte_d     = byte_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        sh_d       = sh_q;
        und_d      = 1'b0;
        ovr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    byte_d     = s_data;
                    last_d     = s_last;
                    byte_cnt_d = 11'd1;
                    cnt_d      = 6'd0;
                    state_d    = S_PRE;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    dib_d   = 2'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            S_DATA: begin
                if (dib_q != 2'd3) begin
                    dib_d = dib_q + 2'd1;
                end else if (last_q) begin
                    dib_d = 2'd0;
                    if (byte_cnt_q < MIN_C) begin
                        state_d = S_PAD;
                    end else begin
                        // fcs_in already folds in the dibit on the line now.
                        sh_d    = fcs_in;
                        cnt_d   = 6'd0;
                        state_d = S_FCS;
                    end
                end else if (!s_valid) begin
                    dib_d   = 2'd0;
                    cnt_d   = 6'd0;
                    und_d   = 1'b1;
                    state_d = S_IFG;
                end else if (byte_cnt_q >= MAX_C) begin
                    dib_d      = 2'd0;
                    cnt_d      = 6'd0;
                    ovr_d      = 1'b1;
                    byte_cnt_d = MAX_C + 11'd1;
                    state_d    = s_last ? S_IFG : S_DRAIN;
                end else begin
                    dib_d      = 2'd0;
                    byte_d     = s_data;
                    last_d     = s_last;
                    byte_cnt_d = byte_cnt_q + 11'd1;
                end
            end
            S_PAD: begin
                if (dib_q != 2'd3) begin
                    dib_d = dib_q + 2'd1;
                end else begin
                    dib_d      = 2'd0;
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    if ((byte_cnt_q + 11'd1) >= MIN_C) begin
                        sh_d    = fcs_in;
                        cnt_d   = 6'd0;
                        state_d = S_FCS;
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end
            S_FCS: begin
                sh_d = sh_q >> 2;
                if (cnt_q == 6'd15) begin
                    cnt_d   = 6'd0;
                    state_d = S_IFG;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            S_DRAIN: begin
                if (s_valid && s_last) begin
                    cnt_d   = 6'd0;
                    state_d = S_IFG;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = 6'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        txd_d    = 2'b00;
        tx_en_d  = 1'b0;
        crc_en_d = 1'b0;
        case (state_d)
            S_PRE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_d == 6'd31) ? 2'b11 : 2'b01;
            end
            S_DATA: begin
                tx_en_d  = 1'b1;
                crc_en_d = 1'b1;
                case (dib_d)
                    2'd0:    txd_d = byte_d[1:0];
                    2'd1:    txd_d = byte_d[3:2];
                    2'd2:    txd_d = byte_d[5:4];
                    default: txd_d = byte_d[7:6];
                endcase
            end
            S_PAD: begin
                tx_en_d  = 1'b1;
                crc_en_d = 1'b1;
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = sh_d[1:0];
            end
            default: begin
                txd_d = 2'b00;
            end
        endcase
        done_d = (state_d == S_FCS) && (cnt_d == 6'd15);
    end

    assign txd          = txd_q;
    assign tx_en        = tx_en_q;
    assign crc_en       = crc_en_q;
    assign crc_data     = txd_q;
    assign frame_done   = done_q;
    assign err_underrun = und_q;
    assign err_oversize = ovr_q;

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Scoreboard bench for rmii_tx_framer: the driver queues the expected line image of each
// frame, and a monitor compares every tx_en burst against it.
module tb_rmii_tx_framer;

    localparam int MINB = 60;
    localparam int MAXB = 1514;
    localparam int IFGC = 48;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [1:0]  txd;
    logic        tx_en;
    logic        crc_en;
    logic [1:0]  crc_data;
    logic [31:0] fcs_in;
    logic        frame_done;
    logic        err_underrun;
    logic        err_oversize;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    rmii_tx_framer #(.MIN_BYTES(MINB), .MAX_BYTES(MAXB), .IFG_CYCLES(IFGC)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .txd(txd), .tx_en(tx_en), .crc_en(crc_en), .crc_data(crc_data),
        .fcs_in(fcs_in), .frame_done(frame_done),
        .err_underrun(err_underrun), .err_oversize(err_oversize)
    );

    // Model of the downstream 2-bit CRC32 block.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [31:0] crc_st = 32'hFFFFFFFF;
    always @(posedge clk) crc_st <= crc_en ? crc_step(crc_st, crc_data) : 32'hFFFFFFFF;
    assign fcs_in = ~crc_step(crc_st, crc_data);

    // Scoreboard
    logic [1:0] exp_dib[$];
    int         exp_len[$];
    int         exp_kind[$];   // 0 normal, 1 underrun, 2 oversize
    bit         exp_gap[$];
    logic [7:0] frm[$];
    bit         mon_en = 1'b0;

    task automatic push_frame(input int kind, input bit gap_exact);
        logic [7:0]  pay[$];
        logic [7:0]  b;
        logic [31:0] c;
        int          nsent;
        int          len;
        nsent = (kind == 2) ? MAXB : frm.size();
        for (int i = 0; i < 31; i++) exp_dib.push_back(2'b01);
        exp_dib.push_back(2'b11);
        for (int i = 0; i < nsent; i++) pay.push_back(frm[i]);
        if (kind == 0) begin
            while (pay.size() < MINB) pay.push_back(8'h00);
        end
        for (int i = 0; i < pay.size(); i++) begin
            b = pay[i];
            for (int k = 0; k < 4; k++) exp_dib.push_back(b[2*k +: 2]);
        end
        len = 32 + 4 * pay.size();
        if (kind == 0) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < pay.size(); i++) begin
                c = c ^ {24'h0, pay[i]};
                for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            c = ~c;
            for (int k = 0; k < 16; k++) exp_dib.push_back(c[2*k +: 2]);
            len = len + 16;
        end
        exp_len.push_back(len);
        exp_kind.push_back(kind);
        exp_gap.push_back(gap_exact);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL handshake: s_ready=%0b after %0d clks, required 1", s_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input int kind, input bit gap_exact);
        int n;
        push_frame(kind, gap_exact);
        for (int i = 0; i < frm.size(); i++)
            send_byte(frm[i], (kind != 1) && (i == frm.size() - 1));
        if (kind == 1) begin
            s_valid = 1'b0;
            n = 0;
            while (tx_en && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic rand_frame(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    endtask

    // Monitor: capture each tx_en burst and check it when tx_en falls.
    initial begin
        logic [1:0] cap[$];
        bit  in_frame, have_fall, gx;
        int  cyc, fall_cyc, gap, done_cnt, done_pos, err_in, crcd_bad;
        int  len, kind, mism;
        logic [1:0] e;
        in_frame = 0; have_fall = 0; cyc = 0; fall_cyc = 0; gap = 0;
        done_cnt = 0; done_pos = 0; err_in = 0; crcd_bad = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                in_frame  = 0;
                have_fall = 0;
            end else if (tx_en) begin
                if (!in_frame) begin
                    in_frame = 1;
                    cap.delete();
                    done_cnt = 0; done_pos = 0; err_in = 0; crcd_bad = 0;
                    gap = have_fall ? (cyc - fall_cyc) : -1;
                end
                cap.push_back(txd);
                if (frame_done) begin done_cnt++; done_pos = cap.size(); end
                if (err_underrun || err_oversize) err_in++;
                if (crc_data != txd) crcd_bad++;
            end else if (in_frame) begin
                in_frame  = 0;
                have_fall = 1;
                fall_cyc  = cyc;
                if (exp_len.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame: got %0d dibits, required no frame", cap.size());
                end else begin
                    len  = exp_len.pop_front();
                    kind = exp_kind.pop_front();
                    gx   = exp_gap.pop_front();
                    total++;
                    if (cap.size() != len) begin
                        bad++;
                        $display("FAIL frame_len: got %0d clks, required %0d (kind %0d)", cap.size(), len, kind);
                    end
                    mism = 0;
                    for (int i = 0; i < len; i++) begin
                        e = exp_dib.pop_front();
                        if (i >= cap.size()) mism++;
                        else if (cap[i] !== e) mism++;
                    end
                    total++;
                    if (mism != 0) begin
                        bad++;
                        $display("FAIL dibits: %0d wrong dibits, required 0 (kind %0d)", mism, kind);
                    end
                    total++;
                    if (done_cnt != ((kind == 0) ? 1 : 0) || (kind == 0 && done_pos != len)) begin
                        bad++;
                        $display("FAIL frame_done: got %0d pulses at dibit %0d, required %0d at %0d",
                                 done_cnt, done_pos, (kind == 0) ? 1 : 0, len);
                    end
                    total++;
                    if (err_underrun != (kind == 1) || err_oversize != (kind == 2) || err_in != 0) begin
                        bad++;
                        $display("FAIL err_pulses: underrun=%0b oversize=%0b in_frame=%0d, required %0b %0b 0",
                                 err_underrun, err_oversize, err_in, kind == 1, kind == 2);
                    end
                    total++;
                    if (crcd_bad != 0) begin
                        bad++;
                        $display("FAIL crc_data: %0d clks differ from txd, required 0", crcd_bad);
                    end
                    if (gx) begin
                        total++;
                        if (gap != IFGC + 1) begin
                            bad++;
                            $display("FAIL ifg_gap: got %0d clks, required %0d", gap, IFGC + 1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({txd, tx_en, crc_en, crc_data, frame_done, err_underrun, err_oversize} != 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {txd, tx_en, crc_en, crc_data, frame_done, err_underrun, err_oversize});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: s_ready=%0b required 1", s_ready); end

        // T1: reset in the middle of DATA.
        @(negedge clk);
        s_valid = 1'b1;
        repeat (70) begin
            s_data = 8'($urandom);
            @(negedge clk);
        end
        total++;
        if (tx_en !== 1'b1) begin bad++; $display("FAIL t1_midframe: tx_en=%0b required 1", tx_en); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (tx_en !== 1'b0 || crc_en !== 1'b0 || txd !== 2'b00) begin
            bad++;
            $display("FAIL t1_reset_now: tx_en=%0b crc_en=%0b txd=%b required 0 0 00", tx_en, crc_en, txd);
        end
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL t1_ready: s_ready=%0b required 1", s_ready); end
        @(negedge clk);
        mon_en = 1'b1;

        // T2: 60 counting bytes.
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        send_frame(0, 1'b0);
        // T3: single byte padded.
        frm.delete();
        frm.push_back(8'hAA);
        send_frame(0, 1'b1);
        // T4: underrun after 9 bytes.
        rand_frame(9);
        send_frame(1, 1'b1);
        // T5: two back-to-back 64-byte frames.
        rand_frame(64);
        send_frame(0, 1'b1);
        rand_frame(64);
        send_frame(0, 1'b1);
        // T6: oversize.
        rand_frame(1520);
        send_frame(2, 1'b1);
        // Length boundaries and random lengths.
        rand_frame(59);
        send_frame(0, 1'b0);
        rand_frame(61);
        send_frame(0, 1'b1);
        rand_frame(MAXB);
        send_frame(0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            rand_frame(int'($urandom_range(2, 200)));
            send_frame(0, 1'b1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;

        n = 0;
        while (exp_len.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (IFGC + 4) @(negedge clk);
        total++;
        if (exp_len.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", exp_len.size());
        end
        total++;
        if (s_ready !== 1'b1 || tx_en !== 1'b0) begin
            bad++;
            $display("FAIL final_idle: s_ready=%0b tx_en=%0b required 1 0", s_ready, tx_en);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
